// File: rtl/sub_bytes_seq.sv
// Multi-cycle AES SubBytes / InvSubBytes engine: LANES S-box lookups per cycle
// over a latched 128-bit state, with a valid/ready handshake on each side.
module sub_bytes_seq #(
  parameter int unsigned LANES  = 4,
  parameter bit          INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int unsigned BEATS = (LANES == 0) ? 1 : 16 / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  localparam logic [0:255][7:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [127:0]   work, work_d;
  logic           inv_q, inv_d;

  // Byte 0 sits in the top bits, so byte b occupies bits [127-8b -: 8].
  function automatic logic [6:0] msb_pos(input int unsigned b);
    return {~4'(b), 3'b111};
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b, input logic use_inv);
    return (INV_EN && use_inv) ? INV[b] : FWD[b];
  endfunction

  // Next-state and working-register update.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    work_d  = work;
    inv_d   = inv_q;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          work_d  = state_in;
          inv_d   = INV_EN & inv;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          work_d[msb_pos(32'(cnt) * LANES + l) -: 8] =
            sbox(work[msb_pos(32'(cnt) * LANES + l) -: 8], inv_q);
        end
        if (cnt == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State plus registered handshake/result outputs, all derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      inv_q     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      state_out <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      work      <= work_d;
      inv_q     <= inv_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      state_out <= (state_d == DONE) ? work_d : '0;
    end
  end

endmodule

// File: doc/sub_bytes_seq.md
SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 Parameter LANES, default 4, S-box lanes per cycle; legal values 1, 2, 4, 8, 16; any other value SHALL fail elaboration.
REQ-002 Parameter INV_EN, default 1, 1 = inverse S-box datapath present, 0 = forward only.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  state_in/inv valid.
REQ-006 in_ready  output  1  block can accept a new state.
REQ-007 inv  input  1  0 = SubBytes, 1 = InvSubBytes; sampled with state_in.
REQ-008 state_in  input  128  state; byte 0 = bits [127:120], byte 15 = bits [7:0].
REQ-009 out_valid  output  1  state_out holds a completed result.
REQ-010 out_ready  input  1  consumer accepts state_out.
REQ-011 state_out  output  128  substituted state, same byte order as state_in.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 FSM states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 IDLE: on in_valid && in_ready, SHALL latch state_in into a 128-bit working register, latch inv, clear beat counter, go to RUN.
REQ-015 RUN: each cycle SHALL replace bytes [cnt*LANES .. cnt*LANES+LANES-1] of the working register with their S-box (or inverse S-box when latched inv=1) values.
REQ-016 Beat counter width = clog2(16/LANES), min 1 bit; increments per RUN cycle; on last beat (cnt = 16/LANES-1) SHALL go to DONE and wrap to 0.
REQ-017 Every one of the 16 bytes SHALL be substituted from its own input value; no byte substituted twice, none skipped.
REQ-018 Latency: acceptance at edge k -> out_valid = 1 after edge k+16/LANES (LANES=16: 1 cycle; LANES=1: 16 cycles).
REQ-019 DONE: out_valid = 1, state_out = working register; both SHALL stay stable until out_ready = 1.
REQ-020 DONE with out_ready = 1: SHALL return to IDLE on that edge; out_valid drops next cycle.
REQ-021 in_valid in RUN/DONE SHALL be ignored (no latch, no state change); upstream holds data until in_ready.
REQ-022 out_ready outside DONE SHALL have no effect.
REQ-023 INV_EN = 0: inv SHALL be ignored, forward S-box always used.
REQ-024 S-box tables SHALL be the FIPS-197 forward and inverse tables, combinational per lane; no output-side combinational path from in_valid/state_in to state_out.
REQ-025 state_out SHALL read 0 whenever out_valid = 0.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, counter 0, working register 0, latched inv 0.
REQ-027 During reset: in_ready = 0, out_valid = 0, busy = 0, state_out = 0; in_ready = 1 first cycle after release.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation; no partial result ever presented.

Verification
REQ-029 LANES=4, inv=0, state_in = 193de3bea0f4e22b9ac68d2ae9f84808 -> after 4 cycles out_valid=1, state_out = d42711aee0bf98f1b8b45de51e415230.
REQ-030 Same vector result fed back with inv=1 -> state_out = 193de3bea0f4e22b9ac68d2ae9f84808; all-zero state, inv=0 -> 63636363636363636363636363636363.
REQ-031 Sweep LANES = 1, 2, 8, 16 with REQ-029 vector -> identical result, out_valid at 16, 8, 2, 1 cycles after acceptance.
REQ-032 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid/state_in -> state_out unchanged, in_ready=0; out_ready=1 -> IDLE, next vector accepted.
REQ-033 Pulse rst_n low on 2nd RUN cycle -> out_valid=0, state_out=0 immediately; subsequent vector processed with full latency and correct result.
REQ-034 Random 1000-vector run vs. FIPS-197 reference model, both modes, random out_ready stalls -> zero mismatches; all 256 byte values covered in every byte position.
